// File: rtl/dsp_sched_pkg.sv
// Shared types, defaults and pointer-update helper for the DSP pre-adder scheduler.
package dsp_sched_pkg;

    localparam int DATA_W_DEF  = 18;
    localparam int DSP_LAT_DEF = 3;
    localparam int ID_W_MAX    = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

    // Next round-robin pointer: one past the winner on a grant, unchanged otherwise.
    function automatic logic [ID_W_MAX-1:0] rr_next(
        input logic [ID_W_MAX-1:0] ptr,
        input logic [ID_W_MAX-1:0] winner,
        input logic                granted,
        input int unsigned         n
    );
        logic [ID_W_MAX-1:0] nxt;
        if (!granted) begin
            nxt = ptr;
        end else if (32'(winner) == (n - 32'd1)) begin
            nxt = '0;
        end else begin
            nxt = winner + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dsp_add_scheduler_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int   idx_s;
    logic found_s;

    // Scan from ptr; the first valid requester wins when enabled.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = (int'(ptr) + k) % N;
            if (en && !found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_idx    = IW'(idx_s);
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/dsp_add_scheduler.sv
// Shares one pipelined DSP pre-adder among NUM_REQ requesters; results return tagged.
module dsp_add_scheduler
    import dsp_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int DSP_LAT = DSP_LAT_DEF,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_d,
    output logic [DATA_W-1:0]           dsp_a,
    output logic [DATA_W-1:0]           dsp_d,
    input  logic [DATA_W:0]             dsp_p,
    output logic                        rsp_valid,
    output logic [IW-1:0]               rsp_id,
    output logic [DATA_W:0]             rsp_result,
    output logic                        idle
);

    logic [NUM_REQ-1:0] grant_s;
    logic [IW-1:0]      grant_idx_s;
    logic               transfer_s;
    logic               any_tag_s;

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [DATA_W-1:0]  dsp_a_q, dsp_a_d;
    logic [DATA_W-1:0]  dsp_d_q, dsp_d_d;
    tag_t               tag_q [0:DSP_LAT];
    tag_t               tag0_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]      rsp_id_q, rsp_id_d;
    logic [DATA_W:0]    rsp_result_q, rsp_result_d;

    // Grants are suppressed while reset is asserted so nothing is offered to requesters.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (en & rst_n),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign req_ready  = grant_s;
    assign transfer_s = |grant_s;

    // Next-state for pointer, issue registers, tag slot 0 and the response register.
    always_comb begin
        ptr_d          = ptr_q;
        dsp_a_d        = dsp_a_q;
        dsp_d_d        = dsp_d_q;
        tag0_d         = '0;
        rsp_valid_d    = tag_q[DSP_LAT].valid;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        if (transfer_s) begin
            ptr_d       = IW'(rr_next(ID_W_MAX'(ptr_q), ID_W_MAX'(grant_idx_s), 1'b1, NUM_REQ));
            dsp_a_d     = req_a[grant_idx_s*DATA_W +: DATA_W];
            dsp_d_d     = req_d[grant_idx_s*DATA_W +: DATA_W];
            tag0_d.valid = 1'b1;
            tag0_d.id    = ID_W_MAX'(grant_idx_s);
        end else begin
            tag0_d = '0;
        end
        if (tag_q[DSP_LAT].valid) begin
            rsp_id_d     = IW'(tag_q[DSP_LAT].id);
            rsp_result_d = dsp_p;
        end else begin
            rsp_id_d     = rsp_id_q;
        end
    end

    // Pointer, issue and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            dsp_a_q      <= '0;
            dsp_d_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            dsp_a_q      <= dsp_a_d;
            dsp_d_q      <= dsp_d_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    // Tag shift register: slot 0 travels with dsp_a/dsp_d, slot DSP_LAT lines up with dsp_p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= DSP_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag0_d;
            for (int i = 1; i <= DSP_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Idle when no tag is in flight and no response is being presented.
    always_comb begin
        any_tag_s = 1'b0;
        for (int i = 0; i <= DSP_LAT; i++) begin
            any_tag_s = any_tag_s | tag_q[i].valid;
        end
        idle = ~any_tag_s & ~rsp_valid_q;
    end

    assign dsp_a      = dsp_a_q;
    assign dsp_d      = dsp_d_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: doc/dsp_add_scheduler.md
# dsp_add_scheduler

Round-robin scheduler that shares one pipelined DSP pre-adder instance (`P = A + D`, 18-bit operands, 19-bit result) among `NUM_REQ` requesters. It accepts at most one operation per cycle via valid/ready handshakes, registers the winning operands into the DSP, and tracks each in-flight operation's requester ID alongside the DSP pipeline. Each result is returned on a single tagged response port. It sits between the requesting datapath blocks and the `dsp_macro_0` instance, which lives outside this block.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `DATA_W`, 18 — operand width; result width is `DATA_W+1`.
- `DSP_LAT`, 3 — DSP cycles from `A`/`D` registered at its input to a valid `P`, ≥1.
- `clk`  in  1  — single clock; all logic is rising-edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `en`  in  1  — when low, no new grants are issued; in-flight operations still drain.
- `req_valid`  in  `NUM_REQ`  — per-requester operation valid.
- `req_ready`  out  `NUM_REQ`  — per-requester grant; at most one bit is high.
- `req_a`  in  `NUM_REQ*DATA_W`  — A operands; requester i at `[i*DATA_W +: DATA_W]`.
- `req_d`  in  `NUM_REQ*DATA_W`  — D operands; same packing.
- `dsp_a`  out  `DATA_W`  — to DSP `A`.
- `dsp_d`  out  `DATA_W`  — to DSP `D`.
- `dsp_p`  in  `DATA_W+1`  — from DSP `P`.
- `rsp_valid`  out  1  — one-cycle result strobe; no backpressure.
- `rsp_id`  out  `$clog2(NUM_REQ)`  — requester index of the result.
- `rsp_result`  out  `DATA_W+1`  — result.
- `idle`  out  1  — no operation in flight or presenting a response.

## Operation
- **Arbitration**
  - Round-robin pointer `ptr`; the search starts at `ptr` and wraps modulo `NUM_REQ`.
  - `req_ready[i]` = `en` & (i is the first requester with `req_valid` set at or after `ptr`).
  - `req_ready` is combinational from `req_valid`, `en` and `ptr`. `req_valid` must not depend on `req_ready`.
- **Handshake**
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
  - On a transfer, `ptr` ← (i+1) mod `NUM_REQ`. Otherwise `ptr` holds.
  - Requesters hold `req_valid` and operands stable until accepted.
- **Issue**
  - On a transfer, `dsp_a`/`dsp_d` ← the winner's operands, and tag slot 0 ← {1, i}.
  - With no transfer, `dsp_a`/`dsp_d` hold their previous values, and tag slot 0 ← {0, 0}.
- **Tag pipeline**
  - `DSP_LAT` stages of {valid, id}, shifted every cycle, aligned with `dsp_p`.
- **Response**
  - On the cycle after the last tag stage: `rsp_valid` ← last tag valid.
  - If that tag is valid: `rsp_id` ← its id and `rsp_result` ← `dsp_p`. Otherwise `rsp_id`/`rsp_result` hold.
- **Arithmetic**
  - The block performs no arithmetic.
  - `dsp_p` bits pass through unmodified. The DSP is configured for two's-complement signed `A+D`.
- `idle` = ~(any tag valid) & ~`rsp_valid`. It is combinational from registers.

## Timing
- **Reset values**
  - `ptr`=0, `dsp_a`=0, `dsp_d`=0, all tags {0,0}.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `idle`=1.
  - `req_ready` is 0 while `rst_n` is low.
- **Latency:** a transfer at cycle t produces `rsp_valid` at t+`DSP_LAT`+2.
- **Throughput:** one operation per cycle. Responses come back in issue order, one per cycle at most.
- **`en` falls:** no transfer that cycle. The pipeline keeps draining, and `idle` rises once it is empty.
- **Single requester:** a requester that is the only one valid is granted every cycle.
- **Contention:** with all requesters valid continuously, grants rotate 0,1,…,`NUM_REQ`-1.
- **Reset mid-operation:** all tags clear immediately and in-flight operations are dropped. No `rsp_valid` is produced for them, and stale `dsp_p` values are ignored.
- **Requester drops `req_valid` without a handshake:** this is a protocol violation. The block behaves as if the request were absent; no assertion is required.

## Structure
- A shared package `dsp_sched_pkg` holds:
  - defaults `DATA_W_DEF`=18, `DSP_LAT_DEF`=3;
  - the tag struct type {valid, id};
  - the function `rr_next(ptr, winner)`.
- One sub-module, `rr_arbiter`:
  - parameter `N`;
  - inputs `req[N]`, `ptr`, `en`;
  - outputs `grant[N]` (one-hot or zero) and `grant_idx`;
  - purely combinational.
- The top level holds `ptr`, the issue registers, the tag shift register, the response register and `idle`.

## Test plan
Bench DSP model: signed 19-bit adder with `DSP_LAT` registers.

1. **Single operation:** requester 2 sends A=0x00005, D=0x00007 at cycle t → `rsp_valid` at t+5, `rsp_id`=2, `rsp_result`=0x0000C. `idle` is low from t+1 to t+5.
2. **Full contention:** all 4 requesters valid from reset with distinct operands → transfers to 0,1,2,3,0,… on consecutive cycles. Responses carry ids 0,1,2,3,… with matching sums, one per cycle.
3. **Fairness:** requesters 1 and 3 held valid continuously → grants alternate 1,3,1,3. Requester 3 is never granted twice in a row.
4. **Sign and width:** A=0x3FFFF, D=0x3FFFF → 0x7FFFE. A=0x20000, D=0x00001 → 0x60001.
5. **Enable:** `en` deasserted for 3 cycles with requesters valid → `req_ready`=0 throughout. Earlier operations still return, `idle` goes high, and granting resumes at `ptr` when `en` returns.
6. **Reset mid-flight:** 3 operations issued, then `rst_n` pulsed low at t+2 → no `rsp_valid` for any of them. All outputs read reset values, and a new request after release returns normally.
